// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared opcodes, state encoding and defaults for the fetch unit
package instr_fetch_unit_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  // True when the top nibble of an instruction word is the halt opcode
  function automatic logic is_hlt(input logic [3:0] opc);
    return opc == OPC_HLT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_timer.sv
// rtl/instr_fetch_unit_timer.sv - saturating wait-cycle counter with clear, enable and expiry flag
module fetch_timer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  // Count enabled cycles, sticking at LIMIT; clear wins over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch between PC updater and instruction memory
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_adv,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic              mem_err,
  output logic [15:0]       fetch_count
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t state_q, state_n;

  logic              mem_req_q,       mem_req_n;
  logic [ADDR_W-1:0] mem_addr_q,      mem_addr_n;
  logic [DATA_W-1:0] instr_q,         instr_n;
  logic              instr_valid_q,   instr_valid_n;
  logic              halted_q,        halted_n;
  logic              mem_err_q,       mem_err_n;
  logic [15:0]       fetch_count_q,   fetch_count_n;
  logic              flush_pending_q, flush_pending_n;

  logic              timer_clear;
  logic              timer_en;
  logic              timer_expired;
  logic [CNT_W-1:0]  timer_count;

  // The timer only runs while a request is outstanding and restarts on each new request
  assign timer_clear = (state_q == ST_IDLE);
  assign timer_en    = (state_q == ST_WAIT);

  fetch_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .en      (timer_en),
    .count   (timer_count),
    .expired (timer_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Datapath and status registers, loaded from the next-state logic below
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      instr_q         <= '0;
      instr_valid_q   <= 1'b0;
      halted_q        <= 1'b0;
      mem_err_q       <= 1'b0;
      fetch_count_q   <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      mem_req_q       <= mem_req_n;
      mem_addr_q      <= mem_addr_n;
      instr_q         <= instr_n;
      instr_valid_q   <= instr_valid_n;
      halted_q        <= halted_n;
      mem_err_q       <= mem_err_n;
      fetch_count_q   <= fetch_count_n;
      flush_pending_q <= flush_pending_n;
    end
  end

  // Next-state and register-update logic; everything holds unless a state says otherwise
  always_comb begin
    state_n         = state_q;
    mem_req_n       = mem_req_q;
    mem_addr_n      = mem_addr_q;
    instr_n         = instr_q;
    instr_valid_n   = instr_valid_q;
    halted_n        = halted_q;
    mem_err_n       = mem_err_q;
    fetch_count_n   = fetch_count_q;
    flush_pending_n = flush_pending_q;
    pc_adv          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // pc_addr is already the redirected target here, so flush needs no action
        pc_adv     = 1'b1;
        mem_addr_n = pc_addr;
        mem_req_n  = 1'b1;
        state_n    = ST_WAIT;
      end

      ST_WAIT: begin
        if (mem_rvalid) begin
          mem_req_n = 1'b0;
          if (flush_pending_q || flush) begin
            // Response to a stale PC: drop it and refetch from the new PC
            flush_pending_n = 1'b0;
            state_n         = ST_IDLE;
          end else begin
            instr_n       = mem_rdata;
            instr_valid_n = 1'b1;
            state_n       = ST_HOLD;
          end
        end else if (timer_expired) begin
          mem_err_n       = 1'b1;
          halted_n        = 1'b1;
          mem_req_n       = 1'b0;
          flush_pending_n = 1'b0;
          state_n         = ST_HALT;
        end else if (flush) begin
          // The read cannot be withdrawn, so remember to discard its data
          flush_pending_n = 1'b1;
        end
      end

      ST_HOLD: begin
        if (flush) begin
          instr_valid_n = 1'b0;
          state_n       = ST_IDLE;
        end else if (instr_ready) begin
          instr_valid_n = 1'b0;
          fetch_count_n = fetch_count_q + 16'd1;
          if (is_hlt(instr_q[DATA_W-1 -: 4])) begin
            halted_n = 1'b1;
            state_n  = ST_HALT;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      ST_HALT: begin
        state_n = ST_HALT;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign mem_err     = mem_err_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_addr;
  logic        pc_adv;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;
  logic        mem_err;
  logic [15:0] fetch_count;

  int n_cmp;
  int n_err;
  int wait_cycles;

  instr_fetch_unit #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_addr     (pc_addr),
    .pc_adv      (pc_adv),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted),
    .mem_err     (mem_err),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    wait_cycles = 0;
    rst_n       = 1'b0;
    pc_addr     = 16'h0000;
    flush       = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 16'h0000;
    instr_ready = 1'b0;

    tick();
    tick();
    check("rst_mem_req",     32'(mem_req),     32'h0);
    check("rst_mem_addr",    32'(mem_addr),    32'h0);
    check("rst_instr",       32'(instr),       32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_halted",      32'(halted),      32'h0);
    check("rst_mem_err",     32'(mem_err),     32'h0);
    check("rst_fetch_count", 32'(fetch_count), 32'h0);
    check("rst_pc_adv",      32'(pc_adv),      32'h1);

    // Reset asserted while a request is outstanding
    rst_n   = 1'b1;
    pc_addr = 16'h0010;
    tick();
    check("midwait_mem_req",  32'(mem_req),  32'h1);
    check("midwait_mem_addr", 32'(mem_addr), 32'h0010);
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req),     32'h0);
    check("async_rst_valid",   32'(instr_valid), 32'h0);
    check("async_rst_pc_adv",  32'(pc_adv),      32'h1);
    check("async_rst_count",   32'(fetch_count), 32'h0);
    tick();
    rst_n = 1'b1;

    // Basic fetch: response two cycles after the request
    pc_addr     = 16'h0002;
    instr_ready = 1'b1;
    check("basic_pc_adv_idle", 32'(pc_adv), 32'h1);
    tick();
    check("basic_mem_req",  32'(mem_req),  32'h1);
    check("basic_mem_addr", 32'(mem_addr), 32'h0002);
    check("basic_no_adv",   32'(pc_adv),   32'h0);
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hA123;
    tick();
    mem_rvalid = 1'b0;
    check("basic_instr_valid", 32'(instr_valid), 32'h1);
    check("basic_instr",       32'(instr),       32'hA123);
    check("basic_req_drop",    32'(mem_req),     32'h0);
    tick();
    check("basic_valid_1cyc", 32'(instr_valid), 32'h0);
    check("basic_count",      32'(fetch_count), 32'h1);
    check("basic_pc_adv",     32'(pc_adv),      32'h1);

    // Backpressure: decode stalls for four cycles
    instr_ready = 1'b0;
    pc_addr     = 16'h0004;
    tick();
    check("bp_mem_addr", 32'(mem_addr), 32'h0004);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hA123;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid_held", 32'(instr_valid), 32'h1);
      check("bp_instr_held", 32'(instr),       32'hA123);
      check("bp_no_req",     32'(mem_req),     32'h0);
      check("bp_no_adv",     32'(pc_adv),      32'h0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    check("bp_count", 32'(fetch_count), 32'h2);

    // Flush while waiting: late response is dropped, refetch from the new PC
    pc_addr = 16'h0006;
    tick();
    check("fw_mem_addr", 32'(mem_addr), 32'h0006);
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    pc_addr = 16'h0040;
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1234;
    tick();
    mem_rvalid = 1'b0;
    check("fw_no_valid", 32'(instr_valid), 32'h0);
    check("fw_req_drop", 32'(mem_req),     32'h0);
    check("fw_pc_adv",   32'(pc_adv),      32'h1);
    tick();
    check("fw_new_addr", 32'(mem_addr), 32'h0040);
    check("fw_new_req",  32'(mem_req),  32'h1);

    // Flush while holding takes priority over ready
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h5555;
    tick();
    mem_rvalid = 1'b0;
    check("fh_valid", 32'(instr_valid), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fh_valid_drop", 32'(instr_valid), 32'h0);
    check("fh_count_same", 32'(fetch_count), 32'h2);
    check("fh_pc_adv",     32'(pc_adv),      32'h1);

    // Delivered-count wrap from 0xFFFF
    force dut.fetch_count_q = 16'hFFFF;
    #1;
    release dut.fetch_count_q;
    pc_addr = 16'h0008;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h2000;
    tick();
    mem_rvalid = 1'b0;
    tick();
    check("wrap_count", 32'(fetch_count), 32'h0);
    check("wrap_not_halted", 32'(halted), 32'h0);

    // HLT delivered: fetch stops for good
    pc_addr = 16'h000A;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hF000;
    tick();
    mem_rvalid = 1'b0;
    check("hlt_instr", 32'(instr), 32'hF000);
    tick();
    check("hlt_halted", 32'(halted),      32'h1);
    check("hlt_count",  32'(fetch_count), 32'h1);
    check("hlt_valid",  32'(instr_valid), 32'h0);
    check("hlt_no_err", 32'(mem_err),     32'h0);
    for (int i = 0; i < 20; i++) begin
      check("hlt_no_req", 32'(mem_req), 32'h0);
      check("hlt_no_adv", 32'(pc_adv),  32'h0);
      tick();
    end

    // Timeout after reset with a memory that never answers
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    pc_addr = 16'h0100;
    tick();
    check("to_req", 32'(mem_req), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    check("to_early_no_err", 32'(mem_err), 32'h0);
    wait_cycles = 4;
    while (mem_err !== 1'b1 && wait_cycles < 4 * TO) begin
      tick();
      wait_cycles++;
    end
    check("to_mem_err",  32'(mem_err), 32'h1);
    check("to_halted",   32'(halted),  32'h1);
    check("to_req_drop", 32'(mem_req), 32'h0);
    check("to_not_early", 32'(wait_cycles >= TO), 32'h1);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h3333;
    tick();
    mem_rvalid = 1'b0;
    flush      = 1'b1;
    tick();
    flush = 1'b0;
    check("to_late_valid", 32'(instr_valid), 32'h0);
    check("to_late_instr", 32'(instr),       32'h0);
    check("to_late_count", 32'(fetch_count), 32'h0);
    check("to_err_sticky", 32'(mem_err),     32'h1);
    check("to_halt_stay",  32'(halted),      32'h1);
    check("to_no_adv",     32'(pc_adv),      32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
